// File: rtl/controle_pkg.sv
// -----------------------------------------------------------------------------
// controle_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - 3-bit instruction opcodes (OP_ADD .. OP_ST)
//   - one-hot ALU operation selects (ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_NOP)
//   - sequencer state enumeration
//   - alu_code_of(): opcode -> ALU select (ALU_NOP for non-ALU opcodes)
// -----------------------------------------------------------------------------
package controle_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_CLR  = 3'b100;
   localparam logic [2:0] OP_STOP = 3'b101;
   localparam logic [2:0] OP_LD   = 3'b110;
   localparam logic [2:0] OP_ST   = 3'b111;

   localparam logic [3:0] ALU_ADD = 4'b1000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_DIV = 4'b0001;
   localparam logic [3:0] ALU_NOP = 4'b0000;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      ALU_WAIT,
      MEM,
      WB,
      CLEAR,
      HALT
   } state_t;

   function automatic logic [3:0] alu_code_of(input logic [2:0] op);
      logic [3:0] code;
      case (op)
         OP_ADD:  code = ALU_ADD;
         OP_SUB:  code = ALU_SUB;
         OP_MUL:  code = ALU_MUL;
         OP_DIV:  code = ALU_DIV;
         default: code = ALU_NOP;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sequenciador_controle_clear_counter.sv
// -----------------------------------------------------------------------------
// clear_counter
// Address generator for the data-memory clear sweep.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : advance one address (high for every CLEAR cycle)
//   o_addr         : current sweep address, 0 while idle
//   o_last         : o_addr is the final word (DEPTH-1)
// The counter folds back to 0 after the last word, so it is already at 0 when
// the next sweep starts and never walks past DEPTH-1.
// -----------------------------------------------------------------------------
module clear_counter #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   output logic [AW-1:0] o_addr,
   output logic          o_last
);

   logic [AW-1:0] r_addr;

   assign o_last = (r_addr == AW'(DEPTH - 1));
   assign o_addr = r_addr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr <= '0;
      end else if (i_en) begin
         r_addr <= o_last ? '0 : r_addr + 1'b1;
      end
   end

endmodule

// File: rtl/sequenciador_controle.sv
// -----------------------------------------------------------------------------
// sequenciador_controle
// Multi-cycle control sequencer for the 3-bit-opcode processor. Fetches an
// opcode, decodes it and steps the datapath enables through EXEC / ALU_WAIT /
// MEM / WB / CLEAR, waiting on handshakes from multi-cycle units.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               leave IDLE and begin fetching
//   imem_ready, opcode  instruction handshake and opcode from instruction memory
//   alu_done            multi-cycle MUL/DIV result ready
//   mem_ready           data-memory access complete
//   imem_req, pc_inc    fetch request, one-cycle PC increment
//   alu_code, alu_start ALU select, one-cycle MUL/DIV launch
//   mem_en, mem_we      data-memory enable and write (1) / read (0)
//   mem_to_reg, reg_we  write-back source select and register write
//   clr_we, clr_addr    clear-sweep write strobe and address
//   busy, halted, error status
//
// Build option: MEM_TIMEOUT_EN adds a MEM watchdog. After TIMEOUT cycles in MEM
// without mem_ready the sequencer halts with error=1. Without it MEM waits
// indefinitely and error is constant 0.
//
// Every output is a flop loaded from the decode of the next state and next IR,
// so each output is a clean Moore function of the state it belongs to.
// -----------------------------------------------------------------------------
module sequenciador_controle
   import controle_pkg::*;
#(
   parameter  int DEPTH   = 16,
   parameter  int TIMEOUT = 64,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          imem_ready,
   input  logic [2:0]    opcode,
   input  logic          alu_done,
   input  logic          mem_ready,
   output logic          imem_req,
   output logic          pc_inc,
   output logic [3:0]    alu_code,
   output logic          alu_start,
   output logic          mem_en,
   output logic          mem_we,
   output logic          mem_to_reg,
   output logic          reg_we,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output logic          busy,
   output logic          halted,
   output logic          error
);

   state_t     r_state, w_next;
   logic [2:0] r_ir, w_ir_next;
   logic       w_clr_last;
   logic       w_to_hit;

   clear_counter #(.DEPTH(DEPTH), .AW(AW)) u_clear_counter (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (r_state == CLEAR),
      .o_addr  (clr_addr),
      .o_last  (w_clr_last)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_to_cnt;

   // Counts completed MEM cycles; fires on the TIMEOUT-th cycle without mem_ready.
   assign w_to_hit = (r_state == MEM) && !mem_ready && (r_to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if ((r_state == MEM) && (w_next == MEM)) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
         r_to_cnt <= '0;
      end
   end
`else
   // No watchdog: MEM waits as long as it takes, TIMEOUT has no effect.
   assign w_to_hit = 1'b0 && (TIMEOUT > 0);
`endif

   // Next state and IR.
   always_comb begin
      w_next    = r_state;
      w_ir_next = r_ir;
      case (r_state)
         IDLE:     if (start) w_next = FETCH;
         FETCH: begin
            if (imem_ready) begin
               w_ir_next = opcode;
               w_next    = DECODE;
            end
         end
         DECODE: begin
            case (r_ir)
               OP_ADD, OP_SUB: w_next = EXEC;
               OP_DIV, OP_MUL: w_next = ALU_WAIT;
               OP_CLR:         w_next = CLEAR;
               OP_LD, OP_ST:   w_next = MEM;
               default:        w_next = HALT;
            endcase
         end
         EXEC:     w_next = WB;
         ALU_WAIT: if (alu_done) w_next = WB;
         MEM: begin
            if (mem_ready) begin
               w_next = (r_ir == OP_LD) ? WB : FETCH;
            end else if (w_to_hit) begin
               w_next = HALT;
            end
         end
         WB:       w_next = FETCH;
         CLEAR:    if (w_clr_last) w_next = FETCH;
         HALT:     w_next = HALT;
         default:  w_next = IDLE;
      endcase
   end

   // Output decode of the state being entered.
   logic       w_imem_req, w_pc_inc, w_alu_start, w_mem_en, w_mem_we;
   logic       w_mem_to_reg, w_reg_we, w_clr_we, w_busy, w_halted;
   logic [3:0] w_alu_code;

   always_comb begin
      w_imem_req   = (w_next == FETCH);
      w_pc_inc     = (w_next == DECODE);
      w_alu_code   = ALU_NOP;
      if ((w_next == EXEC) || (w_next == ALU_WAIT) || (w_next == WB)) begin
         w_alu_code = alu_code_of(w_ir_next);
      end
      // Launch only on entry; staying in ALU_WAIT keeps alu_start low.
      w_alu_start  = (w_next == ALU_WAIT) && (r_state != ALU_WAIT);
      w_mem_en     = (w_next == MEM);
      w_mem_we     = (w_next == MEM) && (w_ir_next == OP_ST);
      w_mem_to_reg = (w_next == WB) && (w_ir_next == OP_LD);
      w_reg_we     = (w_next == WB);
      w_clr_we     = (w_next == CLEAR);
      w_busy       = (w_next != IDLE) && (w_next != HALT);
      w_halted     = (w_next == HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ir       <= 3'b000;
         imem_req   <= 1'b0;
         pc_inc     <= 1'b0;
         alu_code   <= ALU_NOP;
         alu_start  <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_to_reg <= 1'b0;
         reg_we     <= 1'b0;
         clr_we     <= 1'b0;
         busy       <= 1'b0;
         halted     <= 1'b0;
         error      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_ir       <= w_ir_next;
         imem_req   <= w_imem_req;
         pc_inc     <= w_pc_inc;
         alu_code   <= w_alu_code;
         alu_start  <= w_alu_start;
         mem_en     <= w_mem_en;
         mem_we     <= w_mem_we;
         mem_to_reg <= w_mem_to_reg;
         reg_we     <= w_reg_we;
         clr_we     <= w_clr_we;
         busy       <= w_busy;
         halted     <= w_halted;
         // Sticky until reset; HALT is only left through reset anyway.
         error      <= error | w_to_hit;
      end
   end

endmodule

// File: tb/tb_sequenciador_controle.sv
// -----------------------------------------------------------------------------
// tb_sequenciador_controle
// Bench for sequenciador_controle. A reference model turns each instruction
// (opcode plus handshake wait counts) into the cycle-by-cycle list of outputs
// the sequencer must show and the inputs to apply in those cycles. Inputs the
// current step does not sample are filled with random values.
// -----------------------------------------------------------------------------
module tb_sequenciador_controle;

   localparam int DEPTH   = 16;
   localparam int AW      = $clog2(DEPTH);
   localparam int TIMEOUT = 64;
   localparam int SW      = 7;  // {start, imem_ready, opcode[2:0], alu_done, mem_ready}
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct packed {
      logic          imem_req;
      logic          pc_inc;
      logic [3:0]    alu_code;
      logic          alu_start;
      logic          mem_en;
      logic          mem_we;
      logic          mem_to_reg;
      logic          reg_we;
      logic          clr_we;
      logic [AW-1:0] clr_addr;
      logic          busy;
      logic          halted;
      logic          error;
   } outs_t;

   localparam int EW = $bits(outs_t);

   logic          clk, rst_n, start, imem_ready, alu_done, mem_ready;
   logic [2:0]    opcode;
   logic          imem_req, pc_inc, alu_start, mem_en, mem_we, mem_to_reg;
   logic          reg_we, clr_we, busy, halted, error;
   logic [3:0]    alu_code;
   logic [AW-1:0] clr_addr;

   int checks;
   int errors;
   bit model_halted;

   logic [EW-1:0] exp_q[$];
   logic [SW-1:0] stim_q[$];

   sequenciador_controle #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .imem_ready (imem_ready),
      .opcode     (opcode),
      .alu_done   (alu_done),
      .mem_ready  (mem_ready),
      .imem_req   (imem_req),
      .pc_inc     (pc_inc),
      .alu_code   (alu_code),
      .alu_start  (alu_start),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_to_reg (mem_to_reg),
      .reg_we     (reg_we),
      .clr_we     (clr_we),
      .clr_addr   (clr_addr),
      .busy       (busy),
      .halted     (halted),
      .error      (error)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic drive_idle_inputs();
      {start, imem_ready, opcode, alu_done, mem_ready} = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_alu(input logic [2:0] op);
      case (op)
         3'b000:  return 4'b1000;
         3'b001:  return 4'b0100;
         3'b011:  return 4'b0010;
         3'b010:  return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [SW-1:0] noise();
      return SW'($urandom);
   endfunction

   function automatic outs_t observed();
      outs_t o;
      o.imem_req   = imem_req;
      o.pc_inc     = pc_inc;
      o.alu_code   = alu_code;
      o.alu_start  = alu_start;
      o.mem_en     = mem_en;
      o.mem_we     = mem_we;
      o.mem_to_reg = mem_to_reg;
      o.reg_we     = reg_we;
      o.clr_we     = clr_we;
      o.clr_addr   = clr_addr;
      o.busy       = busy;
      o.halted     = halted;
      o.error      = error;
      return o;
   endfunction

   task automatic push(input outs_t e, input logic [SW-1:0] s);
      exp_q.push_back(e);
      stim_q.push_back(s);
   endtask

   task automatic push_idle(input logic go);
      logic [SW-1:0] s;
      s = noise();
      s[6] = go;
      push('0, s);
   endtask

   // Halted: only reset leaves, so start pulses are applied on purpose.
   task automatic push_halt(input int n, input logic err);
      outs_t e;
      logic [SW-1:0] s;
      for (int i = 0; i < n; i++) begin
         e = '0;
         e.halted = 1'b1;
         e.error  = err;
         s = noise();
         if (i % 2 == 0) s[6] = 1'b1;
         push(e, s);
      end
   endtask

   // One instruction from its fetch: fw idle fetch cycles, aw cycles before
   // alu_done, mw cycles before mem_ready.
   task automatic model_instr(input logic [2:0] op, input int fw, input int aw, input int mw);
      outs_t e;
      logic [SW-1:0] s;
      for (int i = 0; i < fw; i++) begin
         e = '0; e.imem_req = 1'b1; e.busy = 1'b1;
         push(e, noise() & 7'b1011111);
      end
      e = '0; e.imem_req = 1'b1; e.busy = 1'b1;
      push(e, (noise() & 7'b1000011) | {2'b01, op, 2'b00});
      e = '0; e.pc_inc = 1'b1; e.busy = 1'b1;
      push(e, noise());
      case (op)
         3'b000, 3'b001: begin
            e = '0; e.alu_code = ref_alu(op); e.busy = 1'b1;
            push(e, noise());
            e.reg_we = 1'b1;
            push(e, noise());
         end
         3'b010, 3'b011: begin
            for (int i = 0; i <= aw; i++) begin
               e = '0; e.alu_code = ref_alu(op); e.alu_start = (i == 0); e.busy = 1'b1;
               s = noise() & 7'b1111101;
               if (i == aw) s[1] = 1'b1;
               push(e, s);
            end
            e = '0; e.alu_code = ref_alu(op); e.reg_we = 1'b1; e.busy = 1'b1;
            push(e, noise());
         end
         3'b110, 3'b111: begin
            for (int i = 0; i <= mw; i++) begin
               if (TO_EN && i == TIMEOUT) begin
                  push_halt(4, 1'b1);
                  model_halted = 1'b1;
                  return;
               end
               e = '0; e.mem_en = 1'b1; e.mem_we = (op == 3'b111); e.busy = 1'b1;
               s = noise() & 7'b1111110;
               if (i == mw) s[0] = 1'b1;
               push(e, s);
            end
            if (op == 3'b110) begin
               e = '0; e.mem_to_reg = 1'b1; e.reg_we = 1'b1; e.busy = 1'b1;
               push(e, noise());
            end
         end
         3'b100: begin
            for (int k = 0; k < DEPTH; k++) begin
               e = '0; e.clr_we = 1'b1; e.clr_addr = AW'(k); e.busy = 1'b1;
               push(e, noise());
            end
         end
         default: begin
            push_halt(4, 1'b0);
            model_halted = 1'b1;
         end
      endcase
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1; imem_ready = 1'b1; opcode = 3'b101; alu_done = 1'b1; mem_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (observed() !== outs_t'('0)) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %h required %h", c, observed(), outs_t'('0));
         end
      end
      do_reset();
   endtask

   task automatic test_program();
      outs_t e;
      logic [SW-1:0] s;
      logic [2:0] op;
      int step;
      do_reset();
      exp_q.delete(); stim_q.delete();
      model_halted = 1'b0;
      push_idle(1'b0);
      push_idle(1'b1);
      model_instr(3'b000, 0, 0, 0);
      model_instr(3'b011, 0, 5, 0);
      model_instr(3'b110, 0, 0, 3);
      model_instr(3'b111, 0, 0, 3);
      model_instr(3'b100, 0, 0, 0);
      model_instr(3'b001, 2, 0, 0);
      model_instr(3'b010, 1, 0, 0);
      for (int n = 0; n < 25; n++) begin
         do op = 3'($urandom_range(0, 7)); while (op == 3'b101);
         model_instr(op, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 5));
      end
      model_instr(3'b101, 1, 0, 0);
      step = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         s = stim_q.pop_front();
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL program step %0d: got %h required %h", step, observed(), e);
         end
         {start, imem_ready, opcode, alu_done, mem_ready} = s;
         @(negedge clk);
         step++;
      end
   endtask

   task automatic test_reset_mid_clear();
      outs_t e;
      logic [SW-1:0] s;
      bit hit;
      do_reset();
      exp_q.delete(); stim_q.delete();
      push_idle(1'b1);
      model_instr(3'b100, 1, 0, 0);
      hit = 1'b0;
      while (exp_q.size() != 0 && !hit) begin
         e = exp_q.pop_front();
         s = stim_q.pop_front();
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL clear_sweep addr %0d: got %h required %h", e.clr_addr, observed(), e);
         end
         if (e.clr_we && e.clr_addr == AW'(7)) begin
            hit = 1'b1;
         end else begin
            {start, imem_ready, opcode, alu_done, mem_ready} = s;
            @(negedge clk);
         end
      end
      // Reset lands between clock edges; outputs must clear without a clock.
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (observed() !== outs_t'('0)) begin
         errors++;
         $display("FAIL async_reset_mid_clear: got %h required %h", observed(), outs_t'('0));
      end
      exp_q.delete(); stim_q.delete();
      drive_idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_mem_hold();
      outs_t e;
      logic [SW-1:0] s;
      int step;
      do_reset();
      exp_q.delete(); stim_q.delete();
      model_halted = 1'b0;
      push_idle(1'b1);
      model_instr(3'b111, 0, 0, 70);
      if (!model_halted) model_instr(3'b000, 0, 0, 0);
      step = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         s = stim_q.pop_front();
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL mem_hold step %0d: got %h required %h", step, observed(), e);
         end
         {start, imem_ready, opcode, alu_done, mem_ready} = s;
         @(negedge clk);
         step++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_halted = 1'b0;
      rst_n = 1'b0;
      drive_idle_inputs();
      test_reset();
      test_program();
      test_reset_mid_clear();
      test_mem_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
